// File: rtl/spi_slave_fsm_if.sv
// spi_slave_fsm_if: SPI pins plus the RAM-side word/byte handshake of the SPI slave.
//   master modport : the SPI master / RAM side (drives SS_n, MOSI, tx_data, tx_valid)
//   slave modport  : spi_slave_fsm (drives MISO, rx_data, rx_valid[, frame_err])
// Optional: `SPI_FRAME_ERR_EN adds the frame_err abort strobe.
interface spi_slave_fsm_if #(
  parameter int DW = 8
);
  logic          SS_n;
  logic          MOSI;
  logic          MISO;
  logic [DW+1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic          frame_err;

  modport master (output SS_n, MOSI, tx_data, tx_valid,
                  input  MISO, rx_data, rx_valid, frame_err);
  modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid, frame_err);
`else
  modport master (output SS_n, MOSI, tx_data, tx_valid,
                  input  MISO, rx_data, rx_valid);
  modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: SPI slave front end for the single-port RAM.
//   Deserialises DW+2-bit MOSI frames (MSB first) into rx_data with a one-cycle
//   rx_valid strobe; after a read-data frame it waits for tx_valid, latches tx_data
//   and shifts it out on MISO, MSB first. Remembers whether a read address has been
//   sent so a command bit of 1 selects READ_ADD or READ_DATA.
// Ports:
//   clk  - system clock, also the SPI bit clock
//   rst  - synchronous active-high reset
//   bus  - spi_slave_fsm_if.slave (SS_n, MOSI, MISO, rx_data, rx_valid, tx_data,
//          tx_valid, frame_err)
// Optional: `SPI_FRAME_ERR_EN enables frame_err, a one-cycle strobe when SS_n rises
//   mid-frame (1..DW+1 bits sampled) or during the tx_valid wait / MISO shift.
module spi_slave_fsm #(
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_fsm_if.slave bus
);

  localparam int CW = $clog2(DW + 3);
  localparam int TW = $clog2(DW);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic [DW:0]   rx_shift, rx_shift_nx;
  logic [DW+1:0] rx_data, rx_data_nx;
  logic          rx_valid, rx_valid_nx;
  logic          rd_addr_seen, rd_seen_nx;
  logic          done, done_nx;         // frame complete, holding until SS_n rises
  logic          tx_wait, tx_wait_nx;   // read-data frame done, waiting for tx_valid
  logic          tx_busy, tx_busy_nx;   // MISO shift in progress
  logic [DW-1:0] tx_shift, tx_shift_nx;
  logic [TW-1:0] tx_cnt, tx_cnt_nx;     // bits still to drive after the current one
  logic          miso, miso_nx;
`ifdef SPI_FRAME_ERR_EN
  logic          frame_err, err_nx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      done         <= 1'b0;
      tx_wait      <= 1'b0;
      tx_busy      <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      miso         <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      bit_cnt      <= bit_cnt_nx;
      rx_shift     <= rx_shift_nx;
      rx_data      <= rx_data_nx;
      rx_valid     <= rx_valid_nx;
      rd_addr_seen <= rd_seen_nx;
      done         <= done_nx;
      tx_wait      <= tx_wait_nx;
      tx_busy      <= tx_busy_nx;
      tx_shift     <= tx_shift_nx;
      tx_cnt       <= tx_cnt_nx;
      miso         <= miso_nx;
`ifdef SPI_FRAME_ERR_EN
      frame_err    <= err_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    rx_shift_nx = rx_shift;
    rx_data_nx  = rx_data;
    rx_valid_nx = 1'b0;
    rd_seen_nx  = rd_addr_seen;
    done_nx     = done;
    tx_wait_nx  = tx_wait;
    tx_busy_nx  = tx_busy;
    tx_shift_nx = tx_shift;
    tx_cnt_nx   = tx_cnt;
    miso_nx     = miso;
`ifdef SPI_FRAME_ERR_EN
    err_nx      = 1'b0;
`endif
    if (state != IDLE && bus.SS_n) begin
      // Deselect: drop any partial frame or MISO shift; rd_addr_seen survives.
      state_nx    = IDLE;
      bit_cnt_nx  = '0;
      rx_shift_nx = '0;
      done_nx     = 1'b0;
      tx_wait_nx  = 1'b0;
      tx_busy_nx  = 1'b0;
      tx_shift_nx = '0;
      tx_cnt_nx   = '0;
      miso_nx     = 1'b0;
`ifdef SPI_FRAME_ERR_EN
      err_nx      = (bit_cnt != '0 && !done) || tx_wait || tx_busy;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.SS_n) state_nx = CHK_CMD;
        end
        CHK_CMD: begin
          rx_shift_nx = {{DW{1'b0}}, bus.MOSI};
          bit_cnt_nx  = CW'(1);
          if (!bus.MOSI)         state_nx = WRITE;
          else if (rd_addr_seen) state_nx = READ_DATA;
          else                   state_nx = READ_ADD;
        end
        default: begin
          if (!done) begin
            if (bit_cnt == CW'(DW + 1)) begin
              rx_data_nx  = {rx_shift, bus.MOSI};
              rx_valid_nx = 1'b1;
              done_nx     = 1'b1;
              bit_cnt_nx  = CW'(DW + 2);
              if (state == READ_ADD) rd_seen_nx = 1'b1;
              if (state == READ_DATA) begin
                rd_seen_nx = 1'b0;
                tx_wait_nx = 1'b1;
              end
            end else begin
              rx_shift_nx = {rx_shift[DW-1:0], bus.MOSI};
              bit_cnt_nx  = bit_cnt + CW'(1);
            end
          end else if (tx_wait) begin
            if (bus.tx_valid) begin
              tx_wait_nx  = 1'b0;
              tx_busy_nx  = 1'b1;
              miso_nx     = bus.tx_data[DW-1];
              tx_shift_nx = {bus.tx_data[DW-2:0], 1'b0};
              tx_cnt_nx   = TW'(DW - 1);
            end
          end else if (tx_busy) begin
            if (tx_cnt != '0) begin
              miso_nx     = tx_shift[DW-1];
              tx_shift_nx = {tx_shift[DW-2:0], 1'b0};
              tx_cnt_nx   = tx_cnt - TW'(1);
            end else begin
              miso_nx    = 1'b0;
              tx_busy_nx = 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.MISO     = miso;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
`ifdef SPI_FRAME_ERR_EN
  assign bus.frame_err = frame_err;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: self-checking bench for spi_slave_fsm. A directed table of
// transactions is followed by randomized ones whose expectations come from a
// transaction-level model (a single read-address flag toggled by command-1 frames).
// frame_err is checked when `SPI_FRAME_ERR_EN is defined.
module tb_spi_slave_fsm;

  localparam int DW = 8;
  localparam int FW = DW + 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic rd_flag = 1'b0;

  always #5 clk = ~clk;

  spi_slave_fsm_if #(.DW(DW)) bus ();
  spi_slave_fsm #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [FW-1:0] frame;
    int            nbits;
    int            delay;
    int            post;
    int            rst_at;
    logic [DW-1:0] txd;
    logic          spur;
    logic          exp_pulse;
    logic [FW-1:0] exp_rxd;
    logic          exp_rd;
  } vec_t;

  vec_t vt [18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level view: a full frame with command bit 1 is a read-data frame
  // exactly when a read address has already been sent; each such frame flips the flag.
  function automatic void model(input logic [FW-1:0] frame, input int nbits,
                                output logic pulse, output logic rd);
    pulse = (nbits == FW);
    rd    = 1'b0;
    if (pulse && frame[FW-1]) begin
      rd      = rd_flag;
      rd_flag = !rd_flag;
    end
  endfunction

  task automatic run_txn(input logic [FW-1:0] frame, input int nbits, input int delay,
                         input int post, input int rst_at, input logic [DW-1:0] txd,
                         input logic spur, input logic exp_pulse,
                         input logic [FW-1:0] exp_rxd, input logic exp_rd);
    logic exp_err;
    logic exp_miso;
    logic hit;
    hit = 1'b0;
    bus.SS_n = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI     = frame[FW-1-i];
      bus.tx_valid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.tx_data  = DW'($urandom);
      tick();
      chk("rx_valid_frame", 32'(bus.rx_valid), 32'(exp_pulse && i == FW - 1));
      if (exp_pulse && i == FW - 1) chk("rx_data", 32'(bus.rx_data), 32'(exp_rxd));
      chk("miso_frame", 32'(bus.MISO), 32'd0);
    end
    if (nbits == FW) begin
      for (int p = 0; p < post && !hit; p++) begin
        if (p == rst_at) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          hit = 1'b1;
          chk("miso_after_rst", 32'(bus.MISO), 32'd0);
          chk("rx_valid_after_rst", 32'(bus.rx_valid), 32'd0);
        end else begin
          bus.MOSI     = 1'($urandom);
          bus.tx_valid = exp_rd ? (p == delay) : (spur ? 1'($urandom_range(0, 1)) : 1'b0);
          bus.tx_data  = (exp_rd && p == delay) ? txd : DW'($urandom);
          tick();
          exp_miso = (exp_rd && p >= delay && p < delay + DW) ? txd[DW-1-(p-delay)] : 1'b0;
          chk("miso_shift", 32'(bus.MISO), 32'(exp_miso));
          chk("rx_valid_post", 32'(bus.rx_valid), 32'd0);
        end
      end
    end
    bus.tx_valid = 1'b0;
    bus.SS_n     = 1'b1;
    tick();
    chk("miso_deselect", 32'(bus.MISO), 32'd0);
    chk("rx_valid_deselect", 32'(bus.rx_valid), 32'd0);
    exp_err = !hit && ((nbits >= 1 && nbits <= FW - 1) ||
                       (nbits == FW && exp_rd && post <= delay + DW));
`ifdef SPI_FRAME_ERR_EN
    chk("frame_err", 32'(bus.frame_err), 32'(exp_err));
`endif
    tick();
`ifdef SPI_FRAME_ERR_EN
    chk("frame_err_one_cycle", 32'(bus.frame_err), 32'd0);
`else
    if (exp_err) chk("rx_valid_after_abort", 32'(bus.rx_valid), 32'd0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pl, rd;
    // frame, nbits, delay, post, rst_at, txd, spur, pulse, rx_data, read-data
    vt[0]  = '{10'h0A5, FW, 0,  2, -1, 8'h00, 1'b0, 1'b1, 10'h0A5, 1'b0}; // write
    vt[1]  = '{10'h203, FW, 0,  2, -1, 8'h00, 1'b0, 1'b1, 10'h203, 1'b0}; // read addr
    vt[2]  = '{10'h300, FW, 0, 10, -1, 8'hC3, 1'b0, 1'b1, 10'h300, 1'b1}; // read data
    vt[3]  = '{10'h3FF, FW, 0,  2, -1, 8'h00, 1'b1, 1'b1, 10'h3FF, 1'b0}; // 2nd 11: addr
    vt[4]  = '{10'h3AB, FW, 3, 13, -1, 8'h5A, 1'b0, 1'b1, 10'h3AB, 1'b1}; // slow RAM
    vt[5]  = '{10'h155,  4, 0,  0, -1, 8'h00, 1'b0, 1'b0, 10'h000, 1'b0}; // abort @4
    vt[6]  = '{10'h0F0, FW, 0,  2, -1, 8'h00, 1'b1, 1'b1, 10'h0F0, 1'b0}; // spurious tx
    vt[7]  = '{10'h000,  0, 0,  0, -1, 8'h00, 1'b0, 1'b0, 10'h000, 1'b0}; // abort @0
    vt[8]  = '{10'h2AA, FW, 0,  2, -1, 8'h00, 1'b0, 1'b1, 10'h2AA, 1'b0};
    vt[9]  = '{10'h301, FW-1, 0, 0, -1, 8'h00, 1'b0, 1'b0, 10'h000, 1'b0}; // abort @9
    vt[10] = '{10'h3C0, FW, 0,  4, -1, 8'h81, 1'b0, 1'b1, 10'h3C0, 1'b1}; // MISO abort
    vt[11] = '{10'h200, FW, 0,  2, -1, 8'h00, 1'b0, 1'b1, 10'h200, 1'b0};
    vt[12] = '{10'h3E7, FW, 1, 10, -1, 8'h96, 1'b0, 1'b1, 10'h3E7, 1'b1}; // just done
    vt[13] = '{10'h2F0, FW, 0,  2, -1, 8'h00, 1'b0, 1'b1, 10'h2F0, 1'b0};
    vt[14] = '{10'h310, FW, 0, 10,  3, 8'hC3, 1'b0, 1'b1, 10'h310, 1'b1}; // rst @3 bits
    vt[15] = '{10'h2F1, FW, 0,  2,  1, 8'h00, 1'b0, 1'b1, 10'h2F1, 1'b0}; // rst clears flag
    vt[16] = '{10'h3FF, FW, 0,  2, -1, 8'h00, 1'b1, 1'b1, 10'h3FF, 1'b0}; // so addr again
    vt[17] = '{10'h355, FW, 2, 12, -1, 8'hA5, 1'b0, 1'b1, 10'h355, 1'b1};

    rst = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    tick();
    tick();
    chk("reset_miso", 32'(bus.MISO), 32'd0);
    chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
`endif
    rst = 1'b0;
    tick();

    for (int v = 0; v < 18; v++) begin
      model(vt[v].frame, vt[v].nbits, pl, rd);
      if (vt[v].rst_at >= 0 && vt[v].rst_at < vt[v].post && vt[v].nbits == FW) rd_flag = 1'b0;
      run_txn(vt[v].frame, vt[v].nbits, vt[v].delay, vt[v].post, vt[v].rst_at, vt[v].txd,
              vt[v].spur, vt[v].exp_pulse, vt[v].exp_rxd, vt[v].exp_rd);
    end

    for (int n = 0; n < 40; n++) begin
      logic [FW-1:0] fr;
      int nb, dl, ps;
      fr = FW'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FW - 1)) : FW;
      model(fr, nb, pl, rd);
      dl = int'($urandom_range(0, 3));
      if (rd) ps = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dl + DW)) : dl + DW + 2;
      else    ps = 2;
      run_txn(fr, nb, dl, ps, -1, DW'($urandom), 1'($urandom), pl, fr, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
